// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - bus bundle between core, debug port, data memory and the arbiter
// Purpose: groups the port-C (core), port-D (DMA/debug) and memory-side signals.
// Ports (slave = arbiter view):
//   port C : c_MemWrite, c_MemRead, c_MemDataType, c_Addr, c_WriteData in; c_ReadData, c_stall out
//   port D : d_req, d_we, d_type, d_addr, d_wdata in; d_gnt, d_rvalid, d_rdata, d_err out
//   memory : MemWrite, MemRead, MemDataType, ALUResult_Addr, WriteData out; ReadData in
interface dmem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             c_MemWrite;
  logic             c_MemRead;
  logic [2:0]       c_MemDataType;
  logic [WIDTH-1:0] c_Addr;
  logic [WIDTH-1:0] c_WriteData;
  logic [WIDTH-1:0] c_ReadData;
  logic             c_stall;

  logic             d_req;
  logic             d_we;
  logic [2:0]       d_type;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [WIDTH-1:0] d_rdata;
  logic             d_err;

  logic             MemWrite;
  logic             MemRead;
  logic [2:0]       MemDataType;
  logic [WIDTH-1:0] ALUResult_Addr;
  logic [WIDTH-1:0] WriteData;
  logic [WIDTH-1:0] ReadData;

  modport slave (
    input  c_MemWrite, c_MemRead, c_MemDataType, c_Addr, c_WriteData,
    output c_ReadData, c_stall,
    input  d_req, d_we, d_type, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output MemWrite, MemRead, MemDataType, ALUResult_Addr, WriteData,
    input  ReadData
  );

  modport master (
    output c_MemWrite, c_MemRead, c_MemDataType, c_Addr, c_WriteData,
    input  c_ReadData, c_stall,
    output d_req, d_we, d_type, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  MemWrite, MemRead, MemDataType, ALUResult_Addr, WriteData,
    output ReadData
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares the single-port data memory between core (port C) and DMA/debug (port D)
// Purpose: fixed priority to port C, with a starvation counter that forces a one-cycle
//          port-D grant (stalling the core) after STARVE_LIMIT consecutive denied cycles.
//          Port-D reads return through a registered d_rvalid/d_rdata/d_err pulse.
// Ports:
//   CPU_clk   : clock, rising edge
//   CPU_rst_n : asynchronous active-low reset
//   bus       : dmem_port_arbiter_if.slave (port C, port D and memory-side signals)
module dmem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DMEM_DEPTH   = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               CPU_clk,
  input  logic               CPU_rst_n,
  dmem_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(4 * DMEM_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    FORCE = 2'd1,
    COOL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_starve_cnt;
  logic             r_rvalid;
  logic             r_err;
  logic [WIDTH-1:0] r_rdata;

  logic             w_c_act;
  logic             w_d_oor;
  logic             w_c_own;
  logic             w_d_own;
  logic             w_force_next;
  logic             w_mem_write;
  logic             w_mem_read;
  logic [2:0]       w_mem_type;
  logic [WIDTH-1:0] w_mem_addr;
  logic [WIDTH-1:0] w_mem_wdata;

  assign w_c_act = bus.c_MemWrite | bus.c_MemRead;
  assign w_d_oor = (bus.d_addr >> AW) != '0;

  // Ownership is a function of the registered state and the live requests.
  // COOL arbitrates exactly like ARB; it only differs in never entering FORCE.
  always_comb begin
    w_c_own = 1'b0;
    w_d_own = 1'b0;
    case (r_state)
      // d_req is held by protocol in FORCE; gating on it avoids a phantom access.
      FORCE:   w_d_own = bus.d_req;
      default: begin
        w_c_own = w_c_act;
        w_d_own = !w_c_act && bus.d_req;
      end
    endcase
  end

  // >= keeps STARVE_LIMIT=1 from saturating past the trigger after a COOL denial.
  assign w_force_next = (r_state == ARB) && bus.d_req && !w_d_own &&
                        (r_starve_cnt >= LIMIT_M1);

  always_comb begin
    w_mem_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_type  = 3'b010;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_c_own) begin
      w_mem_write = bus.c_MemWrite;
      w_mem_read  = bus.c_MemRead;
      w_mem_type  = bus.c_MemDataType;
      w_mem_addr  = bus.c_Addr;
      w_mem_wdata = bus.c_WriteData;
    end else if (w_d_own) begin
      w_mem_write = bus.d_we && !w_d_oor;
      w_mem_read  = !bus.d_we;
      w_mem_type  = bus.d_type;
      w_mem_addr  = bus.d_addr;
      w_mem_wdata = bus.d_wdata;
    end
  end

  // Memory writes are blocked outright while reset is asserted.
  assign bus.MemWrite       = w_mem_write & CPU_rst_n;
  assign bus.MemRead        = w_mem_read;
  assign bus.MemDataType    = w_mem_type;
  assign bus.ALUResult_Addr = w_mem_addr;
  assign bus.WriteData      = w_mem_wdata;

  assign bus.c_ReadData = w_c_own ? bus.ReadData : '0;
  assign bus.c_stall    = (r_state == FORCE) && w_c_act;
  assign bus.d_gnt      = w_d_own;
  assign bus.d_rvalid   = r_rvalid;
  assign bus.d_rdata    = r_rdata;
  assign bus.d_err      = r_err;

  always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
    if (!CPU_rst_n) begin
      r_state      <= ARB;
      r_starve_cnt <= '0;
      r_rvalid     <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        ARB:     if (w_force_next) r_state <= FORCE;
        FORCE:   r_state <= COOL;
        default: r_state <= ARB;
      endcase

      if (!bus.d_req || w_d_own) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != LIMIT) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      r_rvalid <= w_d_own;
      r_err    <= w_d_own && w_d_oor;
      if (w_d_own) begin
        r_rdata <= (!bus.d_we && !w_d_oor) ? bus.ReadData : '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
  localparam int W     = 32;
  localparam int DEPTH = 64;
  localparam int LIM   = 8;
  localparam int AWB   = $clog2(4 * DEPTH);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.WIDTH(W)) bus ();

  dmem_port_arbiter #(.WIDTH(W), .DMEM_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .CPU_clk  (clk),
    .CPU_rst_n(rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] t, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? w[31:16] : w[15:0];
    case (t)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [2:0] t, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (t)
      3'b000, 3'b100: r[{a, 3'b000} +: 8]        = d[7:0];
      3'b001, 3'b101: r[{a[1], 4'b0000} +: 16]   = d[15:0];
      default:        r = d;
    endcase
    return r;
  endfunction

  // Data memory seen by the arbiter: combinational read, write on the rising edge.
  logic [31:0] mem [DEPTH];
  logic        bd_we  = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_val = '0;
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_val;
    else if (bus.MemWrite)
      mem[bus.ALUResult_Addr[7:2]] <= st_merge(mem[bus.ALUResult_Addr[7:2]], bus.WriteData,
                                               bus.MemDataType, bus.ALUResult_Addr[1:0]);
  end
  assign bus.ReadData = ld_ext(mem[bus.ALUResult_Addr[7:2]], bus.MemDataType, bus.ALUResult_Addr[1:0]);

  logic [31:0] golden [DEPTH];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_c(input logic we, input logic re, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] wd);
    bus.c_MemWrite    = we;
    bus.c_MemRead     = re;
    bus.c_MemDataType = t;
    bus.c_Addr        = a;
    bus.c_WriteData   = wd;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [2:0] t,
                         input logic [31:0] a, input logic [31:0] wd);
    bus.d_req   = req;
    bus.d_we    = we;
    bus.d_type  = t;
    bus.d_addr  = a;
    bus.d_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic preload(input logic rnd);
    for (int i = 0; i < DEPTH; i++) begin
      bd_idx = 6'(i);
      bd_val = rnd ? $urandom : (32'hA500_0000 | (i << 8) | i);
      golden[i] = bd_val;
      bd_we = 1'b1;
      next_cycle();
    end
    bd_we = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  c_op;   // {we, re}
    logic [2:0]  c_t;
    logic [31:0] c_a;
    logic [31:0] c_wd;
    logic [1:0]  d_op;   // {req, we}
    logic [2:0]  d_t;
    logic [31:0] d_a;
    logic [31:0] d_wd;
    logic [3:0]  e_ctl;  // {d_gnt, c_stall, MemWrite, MemRead}
    logic [2:0]  e_t;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [1:0]  e_resp; // {d_rvalid, d_err}
  } vec_t;

  function automatic vec_t mk(input logic [1:0] c_op, input logic [2:0] c_t, input logic [31:0] c_a,
                              input logic [31:0] c_wd, input logic [1:0] d_op, input logic [2:0] d_t,
                              input logic [31:0] d_a, input logic [31:0] d_wd, input logic [3:0] e_ctl,
                              input logic [2:0] e_t, input logic [31:0] e_addr, input logic [31:0] e_wd,
                              input logic [1:0] e_resp);
    vec_t v;
    v.c_op = c_op; v.c_t = c_t; v.c_a = c_a; v.c_wd = c_wd;
    v.d_op = d_op; v.d_t = d_t; v.d_a = d_a; v.d_wd = d_wd;
    v.e_ctl = e_ctl; v.e_t = e_t; v.e_addr = e_addr; v.e_wd = e_wd; v.e_resp = e_resp;
    return v;
  endfunction

  vec_t vecs [13];

  logic        pend, dwe, prev_gnt, prev_oor, e_gnt, e_stall, d_oor, c_act;
  logic [2:0]  dt, ct;
  logic [31:0] da, dwd, ca, cwd, prev_rdata;
  int          op, wait_n, dut_wait, max_wait;

  function automatic logic [2:0] rand_type();
    case ($urandom_range(0, 4))
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  function automatic logic [31:0] rand_addr(input logic [2:0] t);
    logic [31:0] a;
    a = 32'($urandom_range(0, 255));
    if (t[1:0] == 2'b01) a[0] = 1'b0;
    if (t == 3'b010) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(2'b00, 3'b010, 32'h0,   32'h0,        2'b00, 3'b010, 32'h0,   32'h0,  4'b0000, 3'b010, 32'h0,   32'h0,        2'b00);
    vecs[1]  = mk(2'b01, 3'b101, 32'h12,  32'h0,        2'b00, 3'b010, 32'h0,   32'h0,  4'b0001, 3'b101, 32'h12,  32'h0,        2'b00);
    vecs[2]  = mk(2'b10, 3'b010, 32'h20,  32'h11223344, 2'b00, 3'b010, 32'h0,   32'h0,  4'b0010, 3'b010, 32'h20,  32'h11223344, 2'b00);
    vecs[3]  = mk(2'b00, 3'b010, 32'h0,   32'h0,        2'b10, 3'b010, 32'h30,  32'h0,  4'b1001, 3'b010, 32'h30,  32'h0,        2'b00);
    vecs[4]  = mk(2'b00, 3'b010, 32'h0,   32'h0,        2'b11, 3'b000, 32'h34,  32'h55, 4'b1010, 3'b000, 32'h34,  32'h55,       2'b10);
    vecs[5]  = mk(2'b00, 3'b010, 32'h0,   32'h0,        2'b11, 3'b010, 32'h400, 32'h99, 4'b1000, 3'b010, 32'h400, 32'h99,       2'b10);
    vecs[6]  = mk(2'b01, 3'b010, 32'h8,   32'h0,        2'b10, 3'b010, 32'h40,  32'h0,  4'b0001, 3'b010, 32'h8,   32'h0,        2'b11);
    vecs[7]  = mk(2'b01, 3'b010, 32'h8,   32'h0,        2'b10, 3'b010, 32'h40,  32'h0,  4'b0001, 3'b010, 32'h8,   32'h0,        2'b00);
    vecs[8]  = mk(2'b00, 3'b010, 32'h0,   32'h0,        2'b10, 3'b010, 32'h40,  32'h0,  4'b1001, 3'b010, 32'h40,  32'h0,        2'b00);
    vecs[9]  = mk(2'b00, 3'b010, 32'h0,   32'h0,        2'b00, 3'b010, 32'h0,   32'h0,  4'b0000, 3'b010, 32'h0,   32'h0,        2'b10);
    vecs[10] = mk(2'b00, 3'b010, 32'h0,   32'h0,        2'b10, 3'b010, 32'h100, 32'h0,  4'b1001, 3'b010, 32'h100, 32'h0,        2'b00);
    vecs[11] = mk(2'b00, 3'b010, 32'h0,   32'h0,        2'b11, 3'b010, 32'hFC,  32'h77, 4'b1010, 3'b010, 32'hFC,  32'h77,       2'b11);
    vecs[12] = mk(2'b00, 3'b010, 32'h0,   32'h0,        2'b00, 3'b010, 32'h0,   32'h0,  4'b0000, 3'b010, 32'h0,   32'h0,        2'b10);

    // Reset with a core store pending: nothing may reach memory.
    drive_c(1'b1, 1'b0, 3'b010, 32'h3C, 32'hFFFF_FFFF);
    drive_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    next_cycle();
    preload(1'b0);
    settle();
    chk("rst_MemWrite", bus.MemWrite, 1'b0);
    chk("rst_d_rvalid", bus.d_rvalid, 1'b0);
    chk("rst_d_err", bus.d_err, 1'b0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    drive_c(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      drive_c(vecs[i].c_op[1], vecs[i].c_op[0], vecs[i].c_t, vecs[i].c_a, vecs[i].c_wd);
      drive_d(vecs[i].d_op[1], vecs[i].d_op[0], vecs[i].d_t, vecs[i].d_a, vecs[i].d_wd);
      settle();
      chk($sformatf("vec%0d", i),
          {bus.d_gnt, bus.c_stall, bus.MemWrite, bus.MemRead, bus.MemDataType,
           bus.ALUResult_Addr, bus.WriteData, bus.d_rvalid, bus.d_err},
          {vecs[i].e_ctl, vecs[i].e_t, vecs[i].e_addr, vecs[i].e_wd, vecs[i].e_resp});
      next_cycle();
    end

    // A: idle core, port-D write then read of 0x04.
    drive_d(1'b1, 1'b1, 3'b010, 32'h04, 32'hDEAD_BEEF);
    settle();
    chk("A_gnt_wr", bus.d_gnt, 1'b1);
    chk("A_memwrite", bus.MemWrite, 1'b1);
    next_cycle();
    drive_d(1'b1, 1'b0, 3'b010, 32'h04, 32'h0);
    settle();
    chk("A_gnt_rd", bus.d_gnt, 1'b1);
    chk("A_rvalid_wr", bus.d_rvalid, 1'b1);
    chk("A_err_wr", bus.d_err, 1'b0);
    next_cycle();
    drive_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    settle();
    chk("A_rvalid_rd", bus.d_rvalid, 1'b1);
    chk("A_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    chk("A_err_rd", bus.d_err, 1'b0);
    next_cycle();
    settle();
    chk("A_rvalid_end", bus.d_rvalid, 1'b0);
    next_cycle();

    // B: continuous core loads starve a port-D read of 0x08 until cycle LIM.
    for (int k = 0; k <= LIM; k++) begin
      drive_c(1'b0, 1'b1, 3'b010, 32'h0, 32'h0);
      drive_d(1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
      settle();
      chk($sformatf("B_gnt_c%0d", k), bus.d_gnt, (k == LIM));
      chk($sformatf("B_stall_c%0d", k), bus.c_stall, (k == LIM));
      if (k == LIM) chk("B_force_addr", {bus.MemRead, bus.ALUResult_Addr, bus.c_ReadData}, {1'b1, 32'h08, 32'h0});
      next_cycle();
    end
    drive_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    settle();
    chk("B_stall_after", bus.c_stall, 1'b0);
    chk("B_core_owns", {bus.MemRead, bus.ALUResult_Addr}, {1'b1, 32'h0});
    chk("B_rvalid", bus.d_rvalid, 1'b1);
    chk("B_rdata", bus.d_rdata, 32'hA500_0202);
    next_cycle();
    drive_c(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    next_cycle();

    // D: out-of-range port-D write is suppressed and flagged.
    drive_d(1'b1, 1'b1, 3'b010, 32'hABCD_E01C, 32'h0BAD_F00D);
    settle();
    chk("D_gnt", bus.d_gnt, 1'b1);
    chk("D_memwrite", bus.MemWrite, 1'b0);
    next_cycle();
    drive_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    drive_c(1'b0, 1'b1, 3'b010, 32'h1C, 32'h0);
    settle();
    chk("D_resp", {bus.d_rvalid, bus.d_err, bus.d_rdata}, {1'b1, 1'b1, 32'h0});
    chk("D_core_lw", bus.c_ReadData, 32'hA500_0707);
    next_cycle();
    drive_c(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    next_cycle();

    // C: core SB and port-D LB of the same byte in the same cycle.
    drive_c(1'b1, 1'b0, 3'b000, 32'h08, 32'h1234_56AA);
    drive_d(1'b1, 1'b0, 3'b000, 32'h08, 32'h0);
    settle();
    chk("C_core_wr", {bus.MemWrite, bus.d_gnt, bus.MemDataType}, {1'b1, 1'b0, 3'b000});
    next_cycle();
    drive_c(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    settle();
    chk("C_gnt_delayed", {bus.d_gnt, bus.MemRead}, {1'b1, 1'b1});
    next_cycle();
    drive_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    settle();
    chk("C_rdata", {bus.d_rvalid, bus.d_rdata}, {1'b1, 32'hFFFF_FFAA});
    next_cycle();
    next_cycle();

    // E: reset asserted mid-cycle with a forced grant due at the next edge.
    for (int k = 0; k < LIM; k++) begin
      drive_c(1'b1, 1'b0, 3'b010, 32'h3C, 32'h5A5A_5A5A);
      drive_d(1'b1, 1'b0, 3'b010, 32'h08, 32'h0);
      settle();
      chk($sformatf("E_pre_gnt%0d", k), bus.d_gnt, 1'b0);
      if (k < LIM - 1) next_cycle();
    end
    chk("E_mw_before_rst", bus.MemWrite, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("E_rst_resp", {bus.d_rvalid, bus.d_err, bus.d_rdata}, {1'b0, 1'b0, 32'h0});
    chk("E_rst_memwrite", bus.MemWrite, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k <= LIM; k++) begin
      settle();
      chk($sformatf("E_post_gnt%0d", k), bus.d_gnt, (k == LIM));
      if (k == LIM) chk("E_post_stall", bus.c_stall, 1'b1);
      next_cycle();
    end
    drive_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    drive_c(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    settle();
    chk("E_post_rdata", {bus.d_rvalid, bus.d_rdata}, {1'b1, 32'hA500_02AA});
    next_cycle();

    // Randomised traffic against a golden memory and a wait-count arbitration model.
    rst_n = 1'b0;
    preload(1'b1);
    rst_n = 1'b1;
    next_cycle();
    pend = 1'b0; dwe = 1'b0; dt = 3'b010; da = '0; dwd = '0;
    prev_gnt = 1'b0; prev_oor = 1'b0; prev_rdata = '0;
    wait_n = 0; dut_wait = 0; max_wait = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      op  = (((cyc / 48) % 2) == 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
      ct  = rand_type();
      ca  = rand_addr(ct);
      cwd = $urandom;
      drive_c(op == 2, op == 1, ct, ca, cwd);
      if (!pend && cyc < 1490 && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        wait_n = 0;
        dwe = 1'($urandom_range(0, 1));
        dt  = rand_type();
        da  = rand_addr(dt);
        if ($urandom_range(0, 7) == 0) da[31:8] = 24'($urandom_range(1, 24'hFF_FFFF));
        dwd = $urandom;
      end
      drive_d(pend, dwe, dt, da, dwd);

      c_act   = (op != 0);
      e_gnt   = pend && (!c_act || wait_n == LIM);
      e_stall = c_act && pend && (wait_n == LIM);
      d_oor   = (da >> AWB) != 0;

      settle();
      chk("rnd_d_gnt", bus.d_gnt, e_gnt);
      chk("rnd_c_stall", bus.c_stall, e_stall);
      chk("rnd_d_rvalid", bus.d_rvalid, prev_gnt);
      if (prev_gnt) begin
        chk("rnd_d_err", bus.d_err, prev_oor);
        chk("rnd_d_rdata", bus.d_rdata, prev_rdata);
      end
      if (op == 1) chk("rnd_c_rdata", bus.c_ReadData, e_stall ? 32'h0 : ld_ext(golden[ca[7:2]], ct, ca[1:0]));

      if (bus.d_req && !bus.d_gnt) dut_wait++;
      else dut_wait = 0;
      if (dut_wait > max_wait) max_wait = dut_wait;

      prev_gnt   = e_gnt;
      prev_oor   = e_gnt && d_oor;
      prev_rdata = (e_gnt && !dwe && !d_oor) ? ld_ext(golden[da[7:2]], dt, da[1:0]) : 32'h0;
      if (op == 2 && !e_stall) golden[ca[7:2]] = st_merge(golden[ca[7:2]], cwd, ct, ca[1:0]);
      if (e_gnt && dwe && !d_oor) golden[da[7:2]] = st_merge(golden[da[7:2]], dwd, dt, da[1:0]);
      if (pend) begin
        if (e_gnt) pend = 1'b0;
        else wait_n++;
      end
      next_cycle();
    end
    drive_c(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    drive_d(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    settle();
    chk("rnd_last_rvalid", bus.d_rvalid, prev_gnt);
    chk("rnd_max_wait", (max_wait <= LIM), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the RV32IM core load/store path (port C) and a secondary DMA/debug port (port D).
- Sits between the core/debug logic and the data memory, and drives its MemWrite/MemRead/MemDataType/ALUResult_Addr/WriteData inputs.
- Port C has fixed priority. A starvation counter forces a one-cycle port-D grant and stalls the core during that cycle.
- Port D reads are captured and returned with a registered valid pulse; out-of-range port-D accesses are flagged and suppressed.

Parameters:
WIDTH, 32, data/address width
DMEM_DEPTH, 64, memory depth in words; sets the legal port-D byte-address range of 4*DMEM_DEPTH
STARVE_LIMIT, 8, number of consecutive denied port-D cycles before a forced grant (minimum 1)

Ports:
CPU_clk  in  1  system clock; all state updates on the rising edge
CPU_rst_n  in  1  asynchronous active-low reset
c_MemWrite  in  1  core store request
c_MemRead  in  1  core load request
c_MemDataType  in  3  core access type (000 B, 001 H, 010 W, 100 BU, 101 HU)
c_Addr  in  WIDTH  core byte address
c_WriteData  in  WIDTH  core store data
c_ReadData  out  WIDTH  memory read data to the core; 0 when port C does not own memory
c_stall  out  1  core must hold its instruction this cycle
d_req  in  1  port-D request; d_we/d_type/d_addr/d_wdata must be held stable until d_gnt
d_we  in  1  1 = write, 0 = read
d_type  in  3  port-D access type, same encoding as c_MemDataType
d_addr  in  WIDTH  port-D byte address
d_wdata  in  WIDTH  port-D write data
d_gnt  out  1  port D owns memory this cycle; the request is consumed at the next rising edge
d_rvalid  out  1  one-cycle pulse, the cycle after every consumed port-D access
d_rdata  out  WIDTH  registered read data (0 for writes and errored accesses)
d_err  out  1  pulses together with d_rvalid when the consumed access was out of range
MemWrite, MemRead  out  1  memory-side controls
MemDataType  out  3  memory-side access type
ALUResult_Addr  out  WIDTH  memory-side address
WriteData  out  WIDTH  memory-side write data
ReadData  in  WIDTH  combinational memory read data

Behaviour:
- Reset: asynchronous, active-low.
  - FSM state = ARB; starve_cnt = 0; d_rvalid = 0; d_rdata = 0; d_err = 0.
  - While CPU_rst_n = 0, MemWrite is forced to 0.
  - A consumed port-D access whose d_rvalid has not yet issued is dropped.
- Definitions: c_act = c_MemWrite | c_MemRead; d_oor = (d_addr >> $clog2(4*DMEM_DEPTH)) != 0.
- FSM states ARB, FORCE, COOL. Ownership is decided combinationally from the registered state plus the current requests.
  - ARB: if c_act, port C owns. Else if d_req, port D owns. Else no owner.
  - FORCE: port D owns; c_stall = c_act. Next state is COOL.
  - COOL: port C owns if c_act; a forced grant is never repeated back-to-back. Port D may still own if c_act = 0 and d_req = 1. Next state is ARB.
  - ARB to FORCE: at the rising edge where d_req & !d_gnt and starve_cnt == STARVE_LIMIT-1.
- starve_cnt:
  - +1 on every edge with d_req & !d_gnt.
  - Cleared on every edge with d_gnt, and whenever d_req = 0.
  - Saturates at STARVE_LIMIT.
- Memory-side muxing (combinational):
  - Port C owner: pass c_* straight through.
  - Port D owner: MemRead = !d_we; MemWrite = d_we & !d_oor; MemDataType = d_type; ALUResult_Addr = d_addr; WriteData = d_wdata.
  - No owner: MemRead = 0, MemWrite = 0, MemDataType = 010, ALUResult_Addr = 0, WriteData = 0.
  - c_stall = 1 makes the core port non-owner that cycle, so no core write occurs.
- d_gnt = port D owner. A write takes effect at the same rising edge at which the memory samples it.
- Port-D response, at the consuming edge:
  - d_rvalid <= 1.
  - d_rdata <= (read & !d_oor) ? ReadData : 0.
  - d_err <= d_oor.
  - Both pulses deassert at the next edge unless another access is consumed.
  - Back-to-back port-D accesses give back-to-back d_rvalid pulses.
- Simultaneous C and D requests with starve_cnt < STARVE_LIMIT-1: port C wins; port D waits.
- Latency:
  - Port D alone: d_gnt in the request cycle; d_rvalid one cycle later.
  - Port D worst case under continuous core traffic: granted on the (STARVE_LIMIT+1)th cycle of the request.
- The core path adds no latency except during a FORCE cycle.

Test Plan:
- Idle core; port D writes DEADBEEF (type 010) to 0x04, then reads 0x04 -> d_gnt in the same cycle for each access; d_rvalid the next cycle; d_rdata = DEADBEEF, d_err = 0.
- c_MemRead held high every cycle, d_req read of 0x08 asserted at cycle 0, STARVE_LIMIT = 8 -> d_gnt = 0 in cycles 0-7; cycle 8 has d_gnt = 1 and c_stall = 1; cycle 9 has c_stall = 0, port C owns, d_rvalid = 1.
- Core SB 0xAA to 0x08 and port D requesting in the same cycle -> core write lands, port D is delayed one cycle; port-D LB of 0x08 returns d_rdata = FFFFFFAA.
- Port-D write to 0xABCDE01C -> MemWrite stays 0, d_err = 1 with d_rvalid; a core LW of 0x1C still returns the preload value.
- Reset asserted mid-cycle while FORCE is pending -> immediately d_rvalid/d_err/d_rdata = 0 and MemWrite = 0; after release, state ARB and starve_cnt = 0, and the next port-D request waits the full STARVE_LIMIT.
- Randomised core and port-D traffic against a golden array -> every port-D read matches; no port-D request waits more than STARVE_LIMIT+1 cycles.
